// File: rtl/bus_seq_ctrl_if.sv
// Transfer channel between the sequence controller and the I2C/SPI bus engine:
// valid/ready request handshake followed by a done pulse carrying the read byte.
interface bus_seq_ctrl_if;
    logic       xfer_valid;
    logic       xfer_ready;
    logic [3:0] xfer_cnfg;
    logic [7:0] xfer_data;
    logic       xfer_done;
    logic [7:0] xfer_rdata;

    modport master (
        output xfer_valid, xfer_cnfg, xfer_data,
        input  xfer_ready, xfer_done, xfer_rdata
    );

    modport slave (
        input  xfer_valid, xfer_cnfg, xfer_data,
        output xfer_ready, xfer_done, xfer_rdata
    );
endinterface

// File: rtl/bus_seq_ctrl.sv
// Program-execution controller: fetches 13-bit sequence words, executes instruction
// words locally and hands transfer words to the bus engine.
module bus_seq_ctrl #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     start_addr,
    input  logic                  resume,
    input  logic                  abort,
    output logic                  mem_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [WORD_W-1:0]     mem_rdata,
    bus_seq_ctrl_if.master        xfer,
    output logic                  busy,
    output logic                  paused,
    output logic                  done,
    output logic                  cmp_flag,
    output logic [ADDR_W-1:0]     pc
);

    if (WORD_W != 13) begin : g_word_w_check
        $error("bus_seq_ctrl: WORD_W must be 13");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_XFER_REQ, S_XFER_WAIT, S_WAIT_CNT, S_PAUSED
    } state_e;

    typedef enum logic [2:0] {
        OP_STOP, OP_WAIT, OP_COMPARE, OP_COMP_JMP,
        OP_PAUSE, OP_UNCOND_JMP, OP_NOP1, OP_NOP2
    } opcode_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        last_rd_q, last_rd_d;
    logic [7:0]        data_q, data_d;
    logic [3:0]        cnfg_q, cnfg_d;
    logic              cmp_q, cmp_d;
    logic              done_q, done_d;

    logic              cmd_xfer;
    opcode_e           opcode;
    logic              op_cnfg;
    logic [7:0]        op_data;
    logic [ADDR_W-1:0] offset, pc_inc, pc_jmp;

    assign cmd_xfer = mem_rdata[0];
    assign opcode   = opcode_e'(mem_rdata[3:1]);
    assign op_cnfg  = mem_rdata[4];
    assign op_data  = mem_rdata[12:5];

    // Jumps are modular: cnfg = 1 steps back ("up" the listing), 0 steps forward.
    assign offset = ADDR_W'(op_data);
    assign pc_inc = pc_q + ADDR_W'(1);
    assign pc_jmp = op_cnfg ? (pc_q - offset) : (pc_q + offset);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        last_rd_d = last_rd_q;
        data_d    = data_q;
        cnfg_d    = cnfg_q;
        cmp_d     = cmp_q;
        done_d    = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pc_d    = start_addr;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: state_d = S_DECODE;
                S_DECODE: begin
                    if (cmd_xfer) begin
                        cnfg_d  = mem_rdata[4:1];
                        data_d  = op_data;
                        state_d = S_XFER_REQ;
                    end else begin
                        state_d = S_FETCH;
                        pc_d    = pc_inc;
                        case (opcode)
                            OP_STOP: begin
                                state_d = S_IDLE;
                                pc_d    = pc_q;
                                done_d  = 1'b1;
                            end
                            OP_WAIT: begin
                                cnt_d = op_data;
                                if (op_data != 8'd0) begin
                                    state_d = S_WAIT_CNT;
                                    pc_d    = pc_q;
                                end
                            end
                            OP_COMPARE:    cmp_d = op_cnfg ? (last_rd_q == op_data)
                                                           : (last_rd_q != op_data);
                            OP_COMP_JMP:   if (cmp_q) pc_d = pc_jmp;
                            OP_PAUSE: begin
                                state_d = S_PAUSED;
                                pc_d    = pc_q;
                            end
                            OP_UNCOND_JMP: pc_d = pc_jmp;
                            default: ;
                        endcase
                    end
                end
                S_XFER_REQ: begin
                    if (xfer.xfer_ready) state_d = S_XFER_WAIT;
                end
                S_XFER_WAIT: begin
                    if (xfer.xfer_done) begin
                        last_rd_d = xfer.xfer_rdata;
                        pc_d      = pc_inc;
                        state_d   = S_FETCH;
                    end
                end
                S_WAIT_CNT: begin
                    // The counter was loaded with a non-zero value; leaving on 1 gives exactly N cycles here.
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                end
                S_PAUSED: begin
                    if (resume) begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            last_rd_q <= '0;
            data_q    <= '0;
            cnfg_q    <= '0;
            cmp_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            last_rd_q <= last_rd_d;
            data_q    <= data_d;
            cnfg_q    <= cnfg_d;
            cmp_q     <= cmp_d;
            done_q    <= done_d;
        end
    end

    assign mem_en          = (state_q == S_FETCH);
    assign mem_addr        = pc_q;
    // Abort withdraws the request in the same cycle it is seen.
    assign xfer.xfer_valid = (state_q == S_XFER_REQ) && !abort;
    assign xfer.xfer_cnfg  = cnfg_q;
    assign xfer.xfer_data  = data_q;
    assign busy            = (state_q != S_IDLE);
    assign paused          = (state_q == S_PAUSED);
    assign done            = done_q;
    assign cmp_flag        = cmp_q;
    assign pc              = pc_q;

endmodule

// File: doc/bus_seq_ctrl.md
Name: bus_seq_ctrl

Overview:
- Program-execution controller for the bus sequencer.
- Fetches 13-bit sequence words from a synchronous program memory and decodes instruction words: stop, wait, compare, conditional and unconditional relative jump, pause, nop.
- Hands bus-transfer words to the protocol engine (I2C or SPI) over a valid/ready + done handshake.
- Sits between the register file (start, resume, abort, status) and the bus engine.

Parameters:
- ADDR_W, 8, program memory address width; the PC wraps modulo 2^ADDR_W.
- WORD_W, 13, sequence word width; fixed, any other value is an elaboration error.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begin execution at start_addr (honoured only in IDLE)
- start_addr  in  ADDR_W  first program address
- resume  in  1  pulse; leave PAUSED
- abort  in  1  pulse; return to IDLE from any state
- mem_en  out  1  program memory read enable
- mem_addr  out  ADDR_W  program memory address
- mem_rdata  in  WORD_W  read data, valid 1 cycle after mem_en
- xfer_valid  out  1  transfer request
- xfer_ready  in  1  engine accepts the request
- xfer_cnfg  out  4  transfer config ([3] ack, [2] write, [1] stop, [0] start for I2C; [0] write for SPI)
- xfer_data  out  8  write byte
- xfer_done  in  1  pulse; transfer complete
- xfer_rdata  in  8  read byte, valid with xfer_done
- busy  out  1  not IDLE
- paused  out  1  in PAUSED
- done  out  1  one-cycle pulse on STOP or abort
- cmp_flag  out  1  last compare result
- pc  out  ADDR_W  current program counter

Behaviour:
- Word layout:
  - [0] cmd_type: 1 = transfer, 0 = instruction.
  - Transfer word: [4:1] cnfg, [12:5] data.
  - Instruction word: [3:1] opcode, [4] cnfg, [12:5] data.
- Reset values: all outputs 0; state IDLE; pc 0; last_rd 0.
- States: IDLE, FETCH, DECODE, XFER_REQ, XFER_WAIT, WAIT_CNT, PAUSED.
- IDLE: on start, pc <= start_addr, go to FETCH. start is ignored in every other state.
- FETCH: mem_en = 1 and mem_addr = pc for one cycle, then go to DECODE. mem_rdata is sampled in DECODE.
- DECODE, transfer word: latch cnfg and data, go to XFER_REQ.
- DECODE, instruction word, by opcode:
  - STOP (0): done pulse, go to IDLE; pc holds.
  - WAIT (1): load counter with data. If data = 0, pc += 1 and go to FETCH; otherwise go to WAIT_CNT, which decrements once per cycle and on reaching 0 does pc += 1 and goes to FETCH. WAIT occupies exactly data extra cycles.
  - COMPARE (2): cnfg = 1 sets cmp_flag <= (last_rd == data); cnfg = 0 sets cmp_flag <= (last_rd != data). Then pc += 1, go to FETCH.
  - COMP_JMP (3): if cmp_flag = 1, pc <= pc - data when cnfg = 1 (up) or pc + data when cnfg = 0 (down); otherwise pc += 1. Go to FETCH. cmp_flag is unchanged.
  - PAUSE (4): go to PAUSED; paused = 1. On resume, pc += 1 and go to FETCH.
  - UNCOND_JMP (5): jump as in COMP_JMP, unconditionally.
  - NOP1/NOP2 (6, 7): pc += 1, go to FETCH.
- Jump offset 0 re-executes the same word; an unconditional jump with offset 0 is an intentional spin, broken only by abort.
- XFER_REQ: xfer_valid = 1; xfer_cnfg and xfer_data are stable until the cycle xfer_ready = 1, then go to XFER_WAIT.
- XFER_WAIT: on xfer_done, last_rd <= xfer_rdata, pc += 1, go to FETCH. xfer_done in the same cycle as the handshake is not expected and is ignored.
- Minimum cost: 2 cycles per instruction word; 3 cycles + engine time per transfer.
- All pc arithmetic is ADDR_W-bit modular, with no wrap error.
- abort has priority over every other event in the same cycle. It forces IDLE, drops xfer_valid immediately (the engine must tolerate this) and pulses done.
- resume outside PAUSED is ignored.
- cmp_flag and last_rd persist across runs; they are cleared only by reset.

Test Plan:
- Reset mid-transfer with xfer_valid = 1 -> all outputs 0 asynchronously; IDLE on release.
- start_addr = 0x10; program: transfer (cnfg 0x5, data 0xA0), STOP -> xfer_valid in cycle 3 after start with cnfg = 0x5, data = 0xA0. With xfer_ready held low 4 cycles, xfer_valid and the fields stay stable. After done, pc = 0x11 and a done pulse follows.
- Read returns 0x3C; COMPARE cnfg = 1, data 0x3C; COMP_JMP up 3 at addr 5 -> cmp_flag = 1, next fetch addr 2. Repeat with read 0x3D -> no jump, next fetch addr 6.
- WAIT data = 4 -> exactly 4 WAIT_CNT cycles between DECODE and the next FETCH. WAIT data = 0 -> 0 cycles.
- PAUSE at addr 7, resume after 10 cycles -> paused high for the whole window, next fetch addr 8. A resume pulse while running has no effect.
- UNCOND_JMP down 2 at addr 0xFF (ADDR_W = 8) -> next fetch addr 0x01. Abort during the spin -> IDLE, done pulse, busy = 0.
